alu_arbiter: RTL

Shares one combinational ALU (32-bit operands, 4-bit ALU control, result plus zero flag) between `NREQ` requesters, e.g. the EX stage and the debug unit. Round-robin arbitration accepts one request at a time, registers its operands onto the ALU, captures result and zero flag, and returns them with the requester ID over a valid/ready response channel. It sits between the requesters and the single ALU instance.

---
 rtl/alu_arbiter_pkg.sv | 30 +++
 rtl/alu_arbiter_rr.sv | 32 +++
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for alu_arbiter: FSM state encoding and the ALU control code map.
// The codes are passed through unchecked; they are named here for clarity in users and benches.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR   = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI   = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLLV  = 4'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = 4'd10;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRLV  = 4'd11;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 4'd12;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRAV  = 4'd13;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSA = 4'd14;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 4'd15;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter: searches from last+1 upward with wrap, zero latency.
// Output is one-hot grant, encoded index and an any-grant flag; no backpressure of its own.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_idx,
  output logic            o_gnt_vld
);

  logic [IDW-1:0] cand;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    cand      = '0;
    // i runs 1..NREQ so the previous winner is examined last
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(i_last) + i) % NREQ);
      if (!o_gnt_vld && i_req[cand]) begin
        o_gnt_vld   = 1'b1;
        o_gnt[cand] = 1'b1;
        o_gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU among NREQ requesters: accept -> EXEC (1 cycle) -> RESP, response valid 2 edges after accept.
// RESP holds until i_rsp_ready and blocks new accepts; ALU_ARB_OPCNT_EN adds the completed-op counter.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*NBITS-1:0]   i_req_op_a,
  input  logic [NREQ*NBITS-1:0]   i_req_op_b,
  input  logic [NREQ*ALU_CTRL_W-1:0] i_req_ctrl,
  output logic [NBITS-1:0]        o_alu_op_a,
  output logic [NBITS-1:0]        o_alu_op_b,
  output logic [ALU_CTRL_W-1:0]   o_alu_ctrl,
  input  logic [NBITS-1:0]        i_alu_result,
  input  logic                    i_alu_zero,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [IDW-1:0]          o_rsp_id,
  output logic [NBITS-1:0]        o_rsp_result,
  output logic                    o_rsp_zero,
  output logic [31:0]             o_op_count
);

  arb_state_t state_q, state_d;
  logic [IDW-1:0]        last_q, last_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [NBITS-1:0]      alu_op_a_q, alu_op_a_d;
  logic [NBITS-1:0]      alu_op_b_q, alu_op_b_d;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [NBITS-1:0]      rsp_result_q, rsp_result_d;
  logic                  rsp_zero_q, rsp_zero_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_vld;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req     (i_req_valid),
    .i_last    (last_q),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_gnt_vld (gnt_vld)
  );

  // Grant is only offered while idle; the arbiter never grants an invalid requester
  assign o_req_ready = (state_q == ST_IDLE) ? gnt : '0;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    alu_op_a_d   = alu_op_a_q;
    alu_op_b_d   = alu_op_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
              alu_op_a_d = i_req_op_a[k*NBITS +: NBITS];
              alu_op_b_d = i_req_op_b[k*NBITS +: NBITS];
              alu_ctrl_d = i_req_ctrl[k*ALU_CTRL_W +: ALU_CTRL_W];
            end
          end
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = i_alu_result;
        rsp_zero_d   = i_alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      last_q       <= IDW'(NREQ - 1);
      id_q         <= '0;
      alu_op_a_q   <= '0;
      alu_op_b_q   <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      alu_op_a_q   <= alu_op_a_d;
      alu_op_b_q   <= alu_op_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign o_alu_op_a   = alu_op_a_q;
  assign o_alu_op_b   = alu_op_b_q;
  assign o_alu_ctrl   = alu_ctrl_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_OPCNT_EN
  logic [31:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (rsp_valid_q && i_rsp_ready) begin
      op_count_d = op_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign o_op_count = op_count_q;
`else
  assign o_op_count = '0;
`endif

endmodule
